// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: per-key state encoding
// and the filter counter width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_t;

  // Counter must hold DEBOUNCE_CYC-1; never narrower than one bit.
  function automatic int cnt_width(input int debounce_cyc);
    return (debounce_cyc < 2) ? 1 : $clog2(debounce_cyc);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One debounce channel: 2-flop synchroniser, polarity normalisation,
// filter FSM with stability counter, and registered level/strobe outputs.
module key_filter_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic           PIN_REL  = KEY_ACTIVE_LOW;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          p;
  key_state_t    state_reg;
  logic [CW-1:0] cnt_reg;

  // Synchroniser idles at the released pin value so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_reg <= PIN_REL;
      sync2_reg <= PIN_REL;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign p = sync2_reg ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (p) begin
            state_reg <= PRESS_FILT;
            cnt_reg   <= '0;
          end
        end
        PRESS_FILT: begin
          if (!p) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= DOWN;
            cnt_reg   <= '0;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DOWN: begin
          if (!p) begin
            state_reg <= REL_FILT;
            cnt_reg   <= '0;
          end
        end
        REL_FILT: begin
          if (p) begin
            state_reg <= DOWN;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-key push-button debouncer: NUM_KEYS independent filter channels
// producing a clean pressed level and one-cycle press/release strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_filter_ch #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
      ) u_ch (
        .clk        (clk),
        .rstn       (rstn),
        .key_in     (key_in[gi]),
        .key_level  (key_level[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce: a run-length reference model
// feeds a strobe scoreboard that a negedge monitor drains and checks.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  key_debounce #(
    .NUM_KEYS      (NK),
    .DEBOUNCE_CYC  (N),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  // Reference model state: pressed-pin history, accepted level, run length.
  logic [NK-1:0] d0 = '0;
  logic [NK-1:0] d1 = '0;
  logic [NK-1:0] lvl = '0;
  int            run[NK];

  // Monitor tallies of observed strobes.
  int npress[NK];
  int nrel[NK];
  int last_press_cyc[NK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a pin sample reaches the filter two edges later; the level flips
  // once the filter has seen N+1 consecutive samples opposite to it.
  initial begin
    for (int k = 0; k < NK; k++) run[k] = 0;
    forever begin
      logic [NK-1:0] p;
      logic [NK-1:0] pr;
      logic [NK-1:0] rl;
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        d0  = '0;
        d1  = '0;
        lvl = '0;
        for (int k = 0; k < NK; k++) run[k] = 0;
      end else begin
        p  = d1;
        d1 = d0;
        d0 = ~key_in;
        pr = '0;
        rl = '0;
        for (int k = 0; k < NK; k++) begin
          if (p[k] != lvl[k]) begin
            run[k]++;
            if (run[k] == N + 1) begin
              lvl[k] = ~lvl[k];
              if (lvl[k]) pr[k] = 1'b1;
              else        rl[k] = 1'b1;
              run[k] = 0;
            end
          end else begin
            run[k] = 0;
          end
        end
        if ((pr | rl) != '0) exp_q.push_back('{cyc: cyc, press: pr, rel: rl});
      end
    end
  end

  // Monitor: level every cycle, strobes whenever the DUT or the model has one.
  initial begin
    for (int k = 0; k < NK; k++) begin
      npress[k] = 0;
      nrel[k] = 0;
      last_press_cyc[k] = -1;
    end
    forever begin
      ev_t e;
      @(negedge clk);
      check("level", 32'(key_level), 32'(lvl));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missed_strobe", 32'(0), 32'({e.press, e.rel}));
      end
      if ((key_press | key_release) != '0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        else e = '{cyc: cyc, press: '0, rel: '0};
        check("press", 32'(key_press), 32'(e.press));
        check("release", 32'(key_release), 32'(e.rel));
        check("press_and_release", 32'(key_press & key_release), 32'(0));
      end
      for (int k = 0; k < NK; k++) begin
        if (key_press[k]) begin
          npress[k]++;
          last_press_cyc[k] = cyc;
        end
        if (key_release[k]) nrel[k]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int p0, r0, p1, p3, r1, r3, p2;
    key_in = '1;
    rstn   = 1'b0;
    tick(3);
    check("reset_level", 32'(key_level), 32'(0));
    check("reset_press", 32'(key_press), 32'(0));
    check("reset_release", 32'(key_release), 32'(0));
    rstn = 1'b1;
    tick(50);
    check("idle_no_press", 32'(npress[0] + npress[1] + npress[2] + npress[3]), 32'(0));
    check("idle_no_release", 32'(nrel[0] + nrel[1] + nrel[2] + nrel[3]), 32'(0));

    // Clean press of key0 with explicit latency from the sampling edge.
    key_in[0] = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) check("press_not_early", 32'(key_press[0]), 32'(1'b0));
      if (i == 10) begin
        check("press_at_edge10", 32'(key_press[0]), 32'(1'b1));
        check("level_at_edge10", 32'(key_level[0]), 32'(1'b1));
      end
    end
    tick(5);
    key_in[0] = 1'b1;
    tick(15);
    check("clean_release_count", 32'(nrel[0]), 32'(1));
    check("clean_level_low", 32'(key_level[0]), 32'(0));

    // Bounce on press, glitch while down, then release.
    p0 = npress[0];
    r0 = nrel[0];
    key_in[0] = 1'b0; tick(3);
    key_in[0] = 1'b1; tick(2);
    key_in[0] = 1'b0; tick(5);
    key_in[0] = 1'b1; tick(1);
    key_in[0] = 1'b0; tick(20);
    check("bounce_one_press", 32'(npress[0] - p0), 32'(1));
    key_in[0] = 1'b1; tick(5);
    key_in[0] = 1'b0; tick(20);
    check("glitch_no_release", 32'(nrel[0] - r0), 32'(0));
    check("glitch_level_high", 32'(key_level[0]), 32'(1));
    key_in[0] = 1'b1; tick(15);
    check("release_one", 32'(nrel[0] - r0), 32'(1));

    // Concurrent presses on keys 1 and 3, then reset during release filtering.
    p1 = npress[1]; p3 = npress[3]; r1 = nrel[1]; r3 = nrel[3];
    key_in[1] = 1'b0;
    key_in[3] = 1'b0;
    tick(15);
    check("conc_press1", 32'(npress[1] - p1), 32'(1));
    check("conc_press3", 32'(npress[3] - p3), 32'(1));
    check("conc_same_cycle", 32'(last_press_cyc[1]), 32'(last_press_cyc[3]));
    key_in[1] = 1'b1;
    key_in[3] = 1'b1;
    tick(5);
    rstn = 1'b0;
    #1;
    check("midrel_reset_level", 32'(key_level), 32'(0));
    check("midrel_reset_strobes", 32'(key_press | key_release), 32'(0));
    tick(3);
    rstn = 1'b1;
    tick(20);
    check("midrel_no_release", 32'((nrel[1] - r1) + (nrel[3] - r3)), 32'(0));

    // Key held through reset is detected again afterwards.
    p2 = npress[2];
    key_in[2] = 1'b0;
    tick(15);
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(15);
    check("held_through_reset", 32'(npress[2] - p2), 32'(2));
    key_in[2] = 1'b1;
    tick(15);

    // Random bouncing on all keys.
    for (int r = 0; r < 60; r++) begin
      key_in = NK'($urandom);
      tick(int'($urandom_range(1, 14)));
    end
    key_in = '1;
    tick(25);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
